// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port between the IF fetch unit (master) and the
// instruction memory (slave): in-order valid/ready requests, and responses
// that always return in order with no backpressure.
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit. Holds the PC, issues in-order fetches and buffers up
// to two returned instructions for IF/ID. It honours the hazard-unit stall
// (pc_en_if) and ID-stage branch redirects; responses that are still in
// flight at a redirect are drained and thrown away.
// Optional build macro FETCH_PERF_EN adds stall/drop performance counters.
module if_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_unit_if.master   imem,
  input  logic              pc_en_if,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid_IF,
  output logic [XLEN-1:0]   inst_IF,
  output logic [XLEN-1:0]   pc_IF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Buffered entries plus outstanding requests may never exceed this.
  localparam logic [2:0] DEPTH3 = 3'(BUF_DEPTH);

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]      out_q, out_d;
  logic [1:0]      drop_q, drop_d;
  logic [1:0]      buf_cnt_q, buf_cnt_d;
  logic [1:0]      pcq_cnt_q, pcq_cnt_d;
  logic [XLEN-1:0] buf_pc_q [2];
  logic [XLEN-1:0] buf_pc_d [2];
  logic [XLEN-1:0] buf_inst_q [2];
  logic [XLEN-1:0] buf_inst_d [2];
  logic [XLEN-1:0] pcq_q [2];
  logic [XLEN-1:0] pcq_d [2];
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [1:0]      buf_idx, pcq_idx;

  logic hs, rsp, redir, pop, push, discard;

  assign hs      = req_valid_q && imem.imem_req_ready;
  assign rsp     = imem.imem_rsp_valid;
  assign redir   = redirect_valid && (state_q != S_IDLE);
  assign pop     = (buf_cnt_q != 2'd0) && pc_en_if && !redir;
  assign push    = rsp && (state_q == S_RUN) && !redir;
  assign discard = rsp && ((state_q == S_DRAIN) || redir);

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = req_addr_q;
  assign inst_valid_IF       = (buf_cnt_q != 2'd0);
  assign inst_IF             = buf_inst_q[0];
  assign pc_IF               = buf_pc_q[0];

  // Next-state: PC, request/drop accounting, pc queue, instruction buffer, FSM.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    for (int i = 0; i < 2; i++) begin
      buf_pc_d[i]   = buf_pc_q[i];
      buf_inst_d[i] = buf_inst_q[i];
      pcq_d[i]      = pcq_q[i];
    end

    out_d = out_q + {1'b0, hs} - {1'b0, rsp};
    if (hs) fetch_pc_d = fetch_pc_q + XLEN'(4);

    // pc queue: head retires with each kept response, tail takes each issued PC
    if (push) pcq_d[0] = pcq_q[1];
    pcq_idx = pcq_cnt_q - {1'b0, push};
    if (hs) begin
      if (pcq_idx == 2'd0) pcq_d[0] = fetch_pc_q;
      else                 pcq_d[1] = fetch_pc_q;
    end
    pcq_cnt_d = pcq_idx + {1'b0, hs};

    // instruction buffer: shift on pop, then append the response behind it
    if (pop) begin
      buf_pc_d[0]   = buf_pc_q[1];
      buf_inst_d[0] = buf_inst_q[1];
    end
    buf_idx = buf_cnt_q - {1'b0, pop};
    if (push) begin
      if (buf_idx == 2'd0) begin
        buf_pc_d[0]   = pcq_q[0];
        buf_inst_d[0] = imem.imem_rsp_data;
      end else begin
        buf_pc_d[1]   = pcq_q[0];
        buf_inst_d[1] = imem.imem_rsp_data;
      end
    end
    buf_cnt_d = buf_idx + {1'b0, push};

    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_DRAIN: begin
        if (rsp) begin
          drop_d = drop_q - 2'd1;
          if (drop_q == 2'd1) state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Everything still outstanding after this cycle is stale once we redirect.
    if (redir) begin
      fetch_pc_d = redirect_pc;
      buf_cnt_d  = 2'd0;
      pcq_cnt_d  = 2'd0;
      drop_d     = out_d;
      state_d    = (out_d != 2'd0) ? S_DRAIN : S_RUN;
    end

    // Request outputs are registered from next state so they hold until ready.
    req_valid_d = (state_d == S_RUN) && (({1'b0, buf_cnt_d} + {1'b0, out_d}) < DEPTH3);
    req_addr_d  = req_valid_d ? fetch_pc_d : '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      out_q       <= 2'd0;
      drop_q      <= 2'd0;
      buf_cnt_q   <= 2'd0;
      pcq_cnt_q   <= 2'd0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
        pcq_q[i]      <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      buf_cnt_q   <= buf_cnt_d;
      pcq_cnt_q   <= pcq_cnt_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]   <= buf_pc_d[i];
        buf_inst_q[i] <= buf_inst_d[i];
        pcq_q[i]      <= pcq_d[i];
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating stall and discarded-response counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (inst_valid_IF && !pc_en_if && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (discard && (drop_cnt_q != 32'hFFFF_FFFF))
      drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      drop_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a one-cycle-latency memory model answers
// each accepted request with (addr ^ MAGIC); popped IF/ID entries and issued
// request addresses are logged and compared with hand-computed sequences.
module tb_if_fetch_unit;
  localparam logic [31:0] MAGIC = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pc_en_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid_IF;
  logic [31:0] inst_IF;
  logic [31:0] pc_IF;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit_if #(.XLEN(32)) bus ();

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .pc_en_if       (pc_en_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid_IF  (inst_valid_IF),
    .inst_IF        (inst_IF),
    .pc_IF          (pc_IF)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_bad = 0;
  bit          rsp_en;
  logic [31:0] pend_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample before the edge, then let the memory model answer.
  task automatic step();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = bus.imem_req_valid && bus.imem_req_ready;
    a  = bus.imem_req_addr;
    if (hs) begin
      req_log.push_back(a);
      $display("%0t req  addr=%h", $time, a);
    end
    if (bus.imem_rsp_valid)
      $display("%0t rsp  data=%h", $time, bus.imem_rsp_data);
    if (inst_valid_IF && pc_en_if && !redirect_valid) begin
      pop_log.push_back(pc_IF);
      $display("%0t pop  pc=%h inst=%h", $time, pc_IF, inst_IF);
      check_eq("pop_inst", inst_IF, pc_IF ^ MAGIC);
    end
    @(posedge clk);
    #1;
    if (hs) pend_q.push_back(a);
    if (rsp_en && pend_q.size() != 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = pend_q.pop_front() ^ MAGIC;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic clear_bench();
    pc_en_if           = 1'b1;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    rsp_en             = 1'b1;
    pend_q.delete();
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bench();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("rst_req_addr", bus.imem_req_addr, 32'h0);
    check_eq("rst_inst_valid", 32'(inst_valid_IF), 32'd0);
    check_eq("rst_inst", inst_IF, 32'h0);
    check_eq("rst_pc", pc_IF, 32'h0);
`ifdef FETCH_PERF_EN
    check_eq("rst_perf_stall", perf_stall_cnt, 32'd0);
    check_eq("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif
    rst_n = 1'b1;
  endtask

  task automatic run_until_pops(input int n, input int limit);
    for (int i = 0; i < limit && pop_log.size() < n; i++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stale_seen;

    // In-order fetch from reset
    do_reset();
    run_until_pops(3, 30);
    check_eq("t1_pops", 32'(pop_log.size()), 32'd3);
    check_eq("t1_pop0", pop_log[0], 32'h0);
    check_eq("t1_pop1", pop_log[1], 32'h4);
    check_eq("t1_pop2", pop_log[2], 32'h8);
    check_eq("t1_req0", req_log[0], 32'h0);
    check_eq("t1_req1", req_log[1], 32'h4);
    check_eq("t1_req2", req_log[2], 32'h8);

    // Stall with head 0x4 for 5 cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (inst_valid_IF && pc_IF == 32'h4) break;
      step();
    end
    pc_en_if = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_hold_pc", pc_IF, 32'h4);
      check_eq("t2_hold_inst", inst_IF, 32'hC0DE_0004);
      step();
    end
    check_eq("t2_full_no_req", 32'(bus.imem_req_valid), 32'd0);
    check_eq("t2_full_valid", 32'(inst_valid_IF), 32'd1);
    check_eq("t2_req_count", 32'(req_log.size()), 32'd3);
    pc_en_if = 1'b1;
    run_until_pops(4, 30);
    check_eq("t2_pop1", pop_log[1], 32'h4);
    check_eq("t2_pop2", pop_log[2], 32'h8);
    check_eq("t2_pop3", pop_log[3], 32'hC);
    check_eq("t2_req3", req_log[3], 32'hC);

    // Redirect with two requests outstanding, then drain
    do_reset();
    rsp_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_log.size() == 2 && !bus.imem_req_valid) break;
      step();
    end
    check_eq("t3_two_out", 32'(req_log.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    stale_seen     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req_valid) break;
      if (inst_valid_IF) stale_seen = 1'b1;
      step();
    end
    check_eq("t3_no_stale", 32'(stale_seen), 32'd0);
    check_eq("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t3_req_addr", bus.imem_req_addr, 32'h100);
    run_until_pops(1, 20);
    check_eq("t3_pop0", pop_log[0], 32'h100);
    for (int i = 0; i < 10; i++) begin
      if (inst_valid_IF) break;
      step();
    end
    pc_en_if = 1'b0;
    repeat (3) step();
    pc_en_if = 1'b1;
`ifdef FETCH_PERF_EN
    check_eq("t7_perf_stall", perf_stall_cnt, 32'd3);
    check_eq("t7_perf_drop", perf_drop_cnt, 32'd2);
`endif

    // Redirect together with the only outstanding response
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (req_log.size() == 1) break;
      step();
    end
    bus.imem_req_ready = 1'b0;
    redirect_valid     = 1'b1;
    redirect_pc        = 32'h200;
    step();
    redirect_valid     = 1'b0;
    bus.imem_req_ready = 1'b1;
    check_eq("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("t4_req_addr", bus.imem_req_addr, 32'h200);
    check_eq("t4_inst_valid", 32'(inst_valid_IF), 32'd0);
    run_until_pops(1, 20);
    check_eq("t4_pop0", pop_log[0], 32'h200);

    // Request held against ready=0
    do_reset();
    bus.imem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_hold_valid", 32'(bus.imem_req_valid), 32'd1);
      check_eq("t5_hold_addr", bus.imem_req_addr, 32'h10);
      step();
    end
    bus.imem_req_ready = 1'b1;
    repeat (6) step();
    check_eq("t5_req0", req_log[0], 32'h10);
    check_eq("t5_req1", req_log[1], 32'h14);

    // PC wrap after redirect near the top of the address space
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    run_until_pops(3, 30);
    check_eq("t6_pop0", pop_log[0], 32'hFFFF_FFF8);
    check_eq("t6_pop1", pop_log[1], 32'hFFFF_FFFC);
    check_eq("t6_pop2", pop_log[2], 32'h0);
    check_eq("t6_req1", req_log[1], 32'hFFFF_FFF8);
    check_eq("t6_req3", req_log[3], 32'h0);

    // Asynchronous reset in the middle of a drain
    rsp_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.imem_req_valid && pend_q.size() != 0) break;
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    check_eq("t8_drain_no_req", 32'(bus.imem_req_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t8_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("t8_req_addr", bus.imem_req_addr, 32'h0);
    check_eq("t8_inst_valid", 32'(inst_valid_IF), 32'd0);
    check_eq("t8_inst", inst_IF, 32'h0);
    check_eq("t8_pc", pc_IF, 32'h0);
    clear_bench();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_log.size() != 0) break;
      step();
    end
    check_eq("t8_first_req", req_log[0], 32'h0);
    run_until_pops(1, 20);
    check_eq("t8_pop0", pop_log[0], 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
